// File: rtl/mult_pkg.sv
// Shared definitions for the sequential arithmetic units (multiplier, future divider).
// Holds the controller state encoding and the operand magnitude helper.
package mult_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Operands arrive already extended to MAX_W; the most negative input maps
  // to its positive magnitude, which still fits the unsigned operand width.
  function automatic logic [MAX_W-1:0] twos_abs(input logic [MAX_W-1:0] value,
                                                input logic             is_signed);
    return (is_signed && value[MAX_W-1]) ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement negate of a wide value; a zero input always yields zero.
module mult_sign_fix #(
  parameter int W2 = 64
) (
  input  logic          neg,
  input  logic [W2-1:0] value,
  output logic [W2-1:0] result
);

  always_comb begin
    result = neg ? (~value + 1'b1) : value;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial-product bit per clock on magnitudes,
// with the sign applied in a single fix-up cycle before the result is published.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] resultado
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, nextState;
  logic               accept;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] fixed;
  logic [CNT_W-1:0]   count;
  logic               neg;
  logic [MAX_W-1:0]   xExt, yExt;
  logic [WIDTH-1:0]   xMag, yMag;

  // Extend operands to the helper width so one package function serves any WIDTH
  always_comb begin
    xExt = {MAX_W{signed_op & X[WIDTH-1]}};
    yExt = {MAX_W{signed_op & Y[WIDTH-1]}};
    xExt[WIDTH-1:0] = X;
    yExt[WIDTH-1:0] = Y;
    xMag = WIDTH'(twos_abs(xExt, signed_op));
    yMag = WIDTH'(twos_abs(yExt, signed_op));
  end

  mult_sign_fix #(
    .W2(2 * WIDTH)
  ) u_sign_fix (
    .neg   (neg),
    .value (acc),
    .result(fixed)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (count == LAST) nextState = ST_FIX;
      end
      ST_FIX: begin
        busy      = 1'b1;
        nextState = ST_DONE;
      end
      ST_DONE: begin
        done  = 1'b1;
        ready = 1'b1;
        // Accepting here gives back-to-back ops without an idle gap
        if (start) begin
          accept    = 1'b1;
          nextState = ST_RUN;
        end else begin
          nextState = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // The multiplier register shifts left instead of computing Y << count each cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      neg       <= 1'b0;
      resultado <= '0;
    end else begin
      if (accept) begin
        mcand  <= xMag;
        mplier <= {{WIDTH{1'b0}}, yMag};
        acc    <= '0;
        count  <= '0;
        neg    <= signed_op & (X[WIDTH-1] ^ Y[WIDTH-1]);
      end else if (state == ST_RUN) begin
        if (mcand[0]) acc <= acc + mplier;
        mcand  <= mcand >> 1;
        mplier <= mplier << 1;
        count  <= count + 1'b1;
      end
      if (state == ST_FIX) resultado <= fixed;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=32 and WIDTH=8 with hand-computed products,
// latency and done-pulse checks, busy-start handling and mid-operation reset.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, sgn32, ready32, busy32, done32;
  logic [31:0] x32, y32;
  logic [63:0] res32;
  logic        start8, sgn8, ready8, busy8, done8;
  logic [7:0]  x8, y8;
  logic [15:0] res8;

  int vectorCount = 0;
  int missCount   = 0;

  seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .signed_op(sgn32),
    .X(x32), .Y(y32), .ready(ready32), .busy(busy32), .done(done32),
    .resultado(res32)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_op(sgn8),
    .X(x8), .Y(y8), .ready(ready8), .busy(busy8), .done(done8),
    .resultado(res8)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Launch one op from idle, then measure latency, result and pulse width
  task automatic applyStimulus(input bit w8, input bit sgn, input logic [31:0] x,
                               input logic [31:0] y, input logic [63:0] expRes,
                               input string tag);
    int lat;
    int expLat;
    expLat = w8 ? 9 : 33;
    if (w8) begin
      sgn8 = sgn; x8 = x[7:0]; y8 = y[7:0]; start8 = 1'b1;
    end else begin
      sgn32 = sgn; x32 = x; y32 = y; start32 = 1'b1;
    end
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (w8 ? done8 : done32) break;
    end
    checkOutput({tag, "_lat"}, 64'(lat), 64'(expLat));
    checkOutput({tag, "_res"}, w8 ? {48'b0, res8} : res32, expRes);
    @(posedge clk); #1;
    checkOutput({tag, "_pulse"}, 64'(w8 ? done8 : done32), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int first;
    bit sawDone;
    logic [31:0] rx, ry;
    logic signed [63:0] sx, sy;
    logic [63:0] expP;

    reset = 1'b1;
    start32 = 1'b0; sgn32 = 1'b0; x32 = '0; y32 = '0;
    start8  = 1'b0; sgn8  = 1'b0; x8  = '0; y8  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 64'(ready32), 64'd1);
    checkOutput("rst_busy",  64'(busy32),  64'd0);
    checkOutput("rst_done",  64'(done32),  64'd0);
    checkOutput("rst_res",   res32,        64'd0);
    checkOutput("rst_res8",  64'(res8),    64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus(0, 0, 32'd157, 32'd298, 64'd46786, "t1");
    applyStimulus(0, 1, -32'sd3, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "t2a");
    applyStimulus(0, 1, -32'sd7, -32'sd9, 64'd63, "t2b");
    applyStimulus(0, 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "minmin32");
    applyStimulus(0, 1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "maxmin32");
    applyStimulus(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "umax32");
    applyStimulus(0, 1, 32'd0, -32'sd1, 64'd0, "negzero32");
    applyStimulus(1, 1, 32'h80, 32'h80, 64'h4000, "t3a");
    applyStimulus(1, 0, 32'hFF, 32'hFF, 64'hFE01, "t3b");
    applyStimulus(1, 1, 32'h00, 32'h80, 64'h0, "t3c");
    applyStimulus(1, 1, 32'h7F, 32'hFD, 64'hFE83, "t3d");

    // start held high while busy; operands churn until the DONE cycle
    sgn32 = 1'b0; x32 = 32'd157; y32 = 32'd298; start32 = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done32) break;
      x32 = $urandom; y32 = $urandom;
    end
    checkOutput("t4_lat1", 64'(lat), 64'd33);
    checkOutput("t4_res1", res32, 64'd46786);
    x32 = 32'd2; y32 = 32'd3;
    first = lat;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat++;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (done32) break;
    end
    checkOutput("t4_gap", 64'(lat - first), 64'd34);
    checkOutput("t4_res2", res32, 64'd6);
    @(posedge clk); #1;

    // reset during RUN aborts the op and clears the result
    sgn32 = 1'b0; x32 = 32'd157; y32 = 32'd298; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("t5_ready", 64'(ready32), 64'd1);
    checkOutput("t5_busy",  64'(busy32),  64'd0);
    checkOutput("t5_done",  64'(done32),  64'd0);
    checkOutput("t5_res",   res32,        64'd0);
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) sawDone = 1'b1;
    end
    checkOutput("t5_noDone", 64'(sawDone), 64'd0);
    applyStimulus(0, 0, 32'd12, 32'd12, 64'd144, "t5_fresh");

    // Short random sweep against the simulator's native multiply
    for (int i = 0; i < 20; i++) begin
      rx = $urandom; ry = $urandom;
      if (i % 2 == 1) begin
        sx = {{32{rx[31]}}, rx};
        sy = {{32{ry[31]}}, ry};
        expP = sx * sy;
      end else begin
        expP = {32'b0, rx} * {32'b0, ry};
      end
      applyStimulus(0, i % 2 == 1, rx, ry, expP, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
